ysyx_22040365_wb_arbiter: RTL and testbench
===========================================

// Module: ysyx_22040365_wb_arbiter
// PURPOSE
//  Writeback stage: the writer that drives the register file write port (wen/waddr/wdata).
//  Merges ALU results (EXU) and load results (LSU) into one registered write per cycle.
//  EXU results are buffered in a FIFO; the LSU uses a one-entry hold register.
//  Keeps a per-register pending-write scoreboard so issue logic can stall RAW hazards.
// PARAMETERS
//  ADDR_WIDTH  5   register index width; the scoreboard has 2**ADDR_WIDTH bits
//  DATA_WIDTH  64  result / register data width
//  FIFO_DEPTH  4   EXU result FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1              clock, all state on posedge
//  rst_n        in   1              asynchronous active-low reset
//  exu_valid    in   1              EXU result valid
//  exu_ready    out  1              EXU FIFO not full
//  exu_wen      in   1              result writes rd; 0 = accept and drop
//  exu_rd       in   ADDR_WIDTH     EXU destination register
//  exu_data     in   DATA_WIDTH     EXU result
//  lsu_valid    in   1              load result valid
//  lsu_ready    out  1              hold register free, or draining this cycle
//  lsu_rd       in   ADDR_WIDTH     load destination register
//  lsu_data     in   DATA_WIDTH     load data
//  issue_valid  in   1              instruction issued that writes issue_rd
//  issue_rd     in   ADDR_WIDTH     register to mark pending
//  sb_busy      out  2**ADDR_WIDTH  pending-write bit per register
//  rf_wen       out  1              register file write enable (registered)
//  rf_waddr     out  ADDR_WIDTH     register file write address (registered)
//  rf_wdata     out  DATA_WIDTH     register file write data (registered)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): FIFO empty, hold empty, sb_busy=0, rf_wen=0, rf_waddr=0,
//    rf_wdata=0. exu_ready and lsu_ready are forced 0 while rst_n=0.
//  - Reset mid-operation: all buffered results are discarded. No write is issued after release.
//  - Handshake: transfer occurs on valid&&ready at posedge. exu_ready=!full.
//    There is no push-through when the FIFO is full.
//  - exu_wen=0 entries are accepted but not enqueued.
//  - Arbitration at each posedge: the LSU hold entry, if full, pops first (fixed priority).
//    Otherwise the FIFO head pops. At most one pop per cycle.
//  - The pop loads rf_wen/rf_waddr/rf_wdata at that edge.
//    rf_wen=1 for exactly one cycle per pop; otherwise 0.
//  - Latency: with the FIFO and hold empty, a handshake at edge E0 pops at E1.
//    rf_wen is high in the cycle after E1, i.e. 2 cycles after the valid cycle.
//  - rd=0: the entry is popped normally, but rf_wen stays 0 and the scoreboard is not touched.
//  - FIFO: circular read/write pointers with one extra wrap bit.
//    Simultaneous push and pop when non-full and non-empty leaves the count unchanged.
//  - Scoreboard set: issue_valid && issue_rd!=0 sets sb_busy[issue_rd] at the edge.
//  - Scoreboard clear: sb_busy[rf_waddr] clears at the edge ending the cycle in which rf_wen=1.
//    From then on a combinational regfile read returns the new value.
//  - Set and clear of the same rd at the same edge: set wins.
//  - The issuer stalls on a busy rd. If it sets a bit that is already busy, the bit stays 1
//    and clears on the first matching write. This is not flagged.
// CONFIGURATION
//  YSYX_22040365_WB_BYPASS_EN defined:
//   - Adds ports byp_raddr in ADDR_WIDTH, byp_hit out 1, byp_data out DATA_WIDTH.
//   - byp_hit = rf_wen && rf_waddr==byp_raddr && byp_raddr!=0, combinational.
//   - byp_data = rf_wdata.
//   - sb_busy clears at the pop edge, one cycle earlier than without the macro.
//  Undefined: the bypass ports are absent and scoreboard clear timing is as in BEHAVIOUR.
// TESTING
//  1. Hold rst_n=0 for 3 cycles -> rf_wen=0, sb_busy=0, exu_ready=0, lsu_ready=0.
//     Release -> exu_ready=1, lsu_ready=1.
//  2. issue rd=5, then EXU rd=5 data=0x1234 -> rf_wen=1, waddr=5, wdata=0x1234
//     2 cycles after the handshake; sb_busy[5] drops 1 cycle later (same cycle if BYPASS_EN).
//  3. LSU rd=3 data=0xA and EXU rd=4 data=0xB in the same cycle -> write rd=3 first,
//     then rd=4 the next cycle.
//  4. Stream LSU every cycle and push 4 EXU results -> exu_ready=0 after the 4th push.
//     Stop LSU -> EXU writes drain in push order with no loss.
//  5. EXU rd=0 data=0xFF, then exu_wen=0 rd=7 -> no rf_wen pulse; sb_busy unchanged.
//  6. Push 3 EXU entries, then assert rst_n=0 mid-drain -> after release no rf_wen
//     and sb_busy=0.

Source files
------------

// File: rtl/ysyx_22040365_wb_arbiter.sv
// ysyx_22040365_wb_arbiter: writeback arbiter merging EXU FIFO and LSU hold into one registered RF write, with pending-write scoreboard.
// Optional bypass port and early scoreboard clear under YSYX_22040365_WB_BYPASS_EN.
module ysyx_22040365_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic                     exu_wen,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic [2**ADDR_WIDTH-1:0] sb_busy,
  output logic                     rf_wen,
  output logic [ADDR_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata
`ifdef YSYX_22040365_WB_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0]    byp_raddr,
  output logic                     byp_hit,
  output logic [DATA_WIDTH-1:0]    byp_data
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NREG = 2**ADDR_WIDTH;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  hold_v_q, hold_v_d;
  logic [ADDR_WIDTH-1:0] hold_rd_q, hold_rd_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [NREG-1:0]       sb_q, sb_d, clr, set;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d, pop_rd;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d, pop_data;
  logic                  empty, full, push, pop, pop_fifo, lsu_acc;
  logic [EW-1:0]         head;
  always_comb begin
    empty       = wptr_q == rptr_q;
    full        = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    exu_ready   = rst_n && !full;
    lsu_ready   = rst_n;
    push        = exu_valid && exu_ready && exu_wen;
    lsu_acc     = lsu_valid && lsu_ready;
    head        = mem_q[rptr_q[PW-1:0]];
    pop_fifo    = !hold_v_q && !empty;
    pop         = hold_v_q || !empty;
    pop_rd      = hold_v_q ? hold_rd_q : head[EW-1:DATA_WIDTH];
    pop_data    = hold_v_q ? hold_data_q : head[DATA_WIDTH-1:0];
    wptr_d      = wptr_q + (PW+1)'(push);
    rptr_d      = rptr_q + (PW+1)'(pop_fifo);
    hold_v_d    = lsu_acc;
    hold_rd_d   = lsu_acc ? lsu_rd : hold_rd_q;
    hold_data_d = lsu_acc ? lsu_data : hold_data_q;
    rf_wen_d    = pop && pop_rd != '0;
    rf_waddr_d  = pop ? pop_rd : rf_waddr_q;
    rf_wdata_d  = pop ? pop_data : rf_wdata_q;
`ifdef YSYX_22040365_WB_BYPASS_EN
    clr         = rf_wen_d ? NREG'(1) << pop_rd : '0;
`else
    clr         = rf_wen_q ? NREG'(1) << rf_waddr_q : '0;
`endif
    set         = (issue_valid && issue_rd != '0) ? NREG'(1) << issue_rd : '0;
    sb_d        = (sb_q & ~clr) | set;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q[PW-1:0]] <= {exu_rd, exu_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      hold_v_q    <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
      sb_q        <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      hold_v_q    <= hold_v_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      sb_q        <= sb_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end
  assign sb_busy  = sb_q;
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
`ifdef YSYX_22040365_WB_BYPASS_EN
  assign byp_hit  = rf_wen_q && rf_waddr_q == byp_raddr && byp_raddr != '0;
  assign byp_data = rf_wdata_q;
`endif
endmodule

// File: tb/tb_ysyx_22040365_wb_arbiter.sv
// tb_ysyx_22040365_wb_arbiter: directed + random stimulus against a queue-based writeback model with a write scoreboard.
module tb_ysyx_22040365_wb_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        exu_valid = 0, exu_wen = 0, lsu_valid = 0, issue_valid = 0;
  logic [4:0]  exu_rd = 0, lsu_rd = 0, issue_rd = 0;
  logic [63:0] exu_data = 0, lsu_data = 0;
  logic        exu_ready, lsu_ready, rf_wen;
  logic [31:0] sb_busy;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
`ifdef YSYX_22040365_WB_BYPASS_EN
  logic [4:0]  byp_raddr = 0;
  logic        byp_hit;
  logic [63:0] byp_data;
`endif
  ysyx_22040365_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .sb_busy(sb_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef YSYX_22040365_WB_BYPASS_EN
    , .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [4:0] rd; logic [63:0] d;} ent_t;
  ent_t        mq[$];
  ent_t        exp_q[$];
  ent_t        mh, m_w, got;
  bit          mh_v = 0, m_full, m_wr;
  logic [31:0] m_busy = 0, m_c;
  int          m_clr = -1;
  int          n_chk = 0, n_fail = 0;
  // Model: LSU hold beats EXU queue, one retire per edge, set beats clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); exp_q.delete(); mh_v = 0; m_busy = 0; m_clr = -1;
    end else begin
      m_full = mq.size() == 4;
      m_wr = 0;
      m_c = 0;
      if (mh_v) begin m_w = mh; m_wr = 1; mh_v = 0; end
      else if (mq.size() > 0) begin m_w = mq.pop_front(); m_wr = 1; end
      if (m_clr >= 0) m_c[m_clr] = 1'b1;
      m_clr = -1;
      if (m_wr && m_w.rd != 0) begin
        exp_q.push_back(m_w);
`ifdef YSYX_22040365_WB_BYPASS_EN
        m_c[m_w.rd] = 1'b1;
`else
        m_clr = m_w.rd;
`endif
      end
      m_busy = m_busy & ~m_c;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (exu_valid && !m_full && exu_wen) mq.push_back({exu_rd, exu_data});
      if (lsu_valid) begin mh_v = 1; mh = {lsu_rd, lsu_data}; end
    end
  end
  always @(negedge clk) begin
    if (rf_wen) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL unexpected_write: got rd=%0d data=%h, none expected", rf_waddr, rf_wdata);
      end else begin
        got = exp_q.pop_front();
        if (rf_waddr !== got.rd || rf_wdata !== got.d) begin
          n_fail++; $display("FAIL write: got rd=%0d data=%h want rd=%0d data=%h", rf_waddr, rf_wdata, got.rd, got.d);
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_write: rf_wen=%0d, want rd=%0d data=%h", rf_wen, exp_q[0].rd, exp_q[0].d);
      exp_q.delete();
    end
    n_chk++;
    if (sb_busy !== m_busy) begin
      n_fail++; $display("FAIL sb_busy: got %h want %h", sb_busy, m_busy);
    end
    n_chk++;
    if (exu_ready !== (rst_n && mq.size() < 4) || lsu_ready !== rst_n) begin
      n_fail++; $display("FAIL ready: got exu=%0d lsu=%0d want exu=%0d lsu=%0d", exu_ready, lsu_ready, rst_n && mq.size() < 4, rst_n);
    end
`ifdef YSYX_22040365_WB_BYPASS_EN
    n_chk++;
    if (byp_hit !== (rf_wen && rf_waddr == byp_raddr && byp_raddr != 0) || (byp_hit && byp_data !== rf_wdata)) begin
      n_fail++; $display("FAIL bypass: got hit=%0d data=%h", byp_hit, byp_data);
    end
`endif
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic idle();
    exu_valid = 0; lsu_valid = 0; issue_valid = 0; exu_wen = 0;
  endtask
  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] w);
    n_chk++;
    if (g !== w) begin n_fail++; $display("FAIL %s: got %h want %h", nm, g, w); end
  endtask
  task automatic exu(input logic w, input logic [4:0] rd, input logic [63:0] d);
    exu_valid = 1; exu_wen = w; exu_rd = rd; exu_data = d;
  endtask
  initial begin
    repeat (3) step();
    chk("rst_exu_ready", 64'(exu_ready), 0);
    chk("rst_lsu_ready", 64'(lsu_ready), 0);
    chk("rst_rf_wen", 64'(rf_wen), 0);
    chk("rst_sb_busy", 64'(sb_busy), 0);
    rst_n = 1; #1;
    chk("rel_exu_ready", 64'(exu_ready), 1);
    chk("rel_lsu_ready", 64'(lsu_ready), 1);
    issue_valid = 1; issue_rd = 5; step();
    issue_valid = 0; exu(1, 5, 64'h1234); step();
    idle(); step();
    chk("lat_wen", 64'(rf_wen), 1);
    chk("lat_waddr", 64'(rf_waddr), 5);
    chk("lat_wdata", rf_wdata, 64'h1234);
    repeat (3) step();
    lsu_valid = 1; lsu_rd = 3; lsu_data = 64'hA; exu(1, 4, 64'hB); step();
    idle(); step();
    chk("prio_first", 64'(rf_waddr), 3);
    step();
    chk("prio_second", 64'(rf_waddr), 4);
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1; lsu_rd = 5'(20 + i); lsu_data = {$urandom, $urandom};
      if (i < 4) exu(1, 5'(8 + i), 64'(100 + i)); else exu_valid = 0;
      step();
    end
    chk("full_exu_ready", 64'(exu_ready), 0);
    idle(); repeat (8) step();
    exu(1, 0, 64'hFF); step();
    exu(0, 7, 64'h77); step();
    idle(); repeat (4) step();
    issue_valid = 1; issue_rd = 9; step();
    for (int i = 0; i < 3; i++) begin exu(1, 5'(12 + i), 64'(200 + i)); step(); end
    idle(); step();
    rst_n = 0; repeat (2) step();
    chk("midrst_sb", 64'(sb_busy), 0);
    rst_n = 1; repeat (6) step();
    for (int i = 0; i < 3000; i++) begin
      exu_valid = 1'($urandom); exu_wen = ($urandom % 4) != 0;
      exu_rd = 5'($urandom_range(0, 7)); exu_data = {$urandom, $urandom};
      lsu_valid = ($urandom % 3) == 0; lsu_rd = 5'($urandom_range(0, 7)); lsu_data = {$urandom, $urandom};
      issue_valid = 1'($urandom); issue_rd = 5'($urandom_range(0, 7));
`ifdef YSYX_22040365_WB_BYPASS_EN
      byp_raddr = 5'($urandom_range(0, 7));
`endif
      step();
    end
    idle(); repeat (12) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
